// File: rtl/alu_operand_stage_pkg.sv
// Shared ALU op encodings and the registered ALU input bundle.
// Imported by the operand stage and its bypass mux.
package alu_operand_stage_pkg;

    localparam int XLEN   = 32;
    localparam int REG_W  = 5;
    localparam int CTRL_W = 4;

    localparam logic [CTRL_W-1:0] CTRL_ALU_ADD  = 4'd0;
    localparam logic [CTRL_W-1:0] CTRL_ALU_SUB  = 4'd1;
    localparam logic [CTRL_W-1:0] CTRL_ALU_SLT  = 4'd2;
    localparam logic [CTRL_W-1:0] CTRL_ALU_SLTU = 4'd3;
    localparam logic [CTRL_W-1:0] CTRL_ALU_AND  = 4'd4;
    localparam logic [CTRL_W-1:0] CTRL_ALU_OR   = 4'd5;
    localparam logic [CTRL_W-1:0] CTRL_ALU_XOR  = 4'd6;
    localparam logic [CTRL_W-1:0] CTRL_ALU_NOR  = 4'd7;
    localparam logic [CTRL_W-1:0] CTRL_ALU_SLL  = 4'd8;
    localparam logic [CTRL_W-1:0] CTRL_ALU_SRL  = 4'd9;
    localparam logic [CTRL_W-1:0] CTRL_ALU_SRA  = 4'd10;
    localparam logic [CTRL_W-1:0] CTRL_ALU_LUI  = 4'd11;

    typedef struct packed {
        logic              en;
        logic [CTRL_W-1:0] control;
        logic [REG_W-1:0]  rd;
        logic [XLEN-1:0]   sr0;
        logic [XLEN-1:0]   sr1;
    } alu_in_t;

    function automatic logic is_alu_shift(input logic [CTRL_W-1:0] ctrl);
        return (ctrl == CTRL_ALU_SLL) ||
               (ctrl == CTRL_ALU_SRL) ||
               (ctrl == CTRL_ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_operand_stage_bypass_mux.sv
// Resolves one source register: x0, ALU bypass, WB bypass, regfile.
// The ALU result is younger than WB, so it wins on a double match.
module alu_bypass_mux
    import alu_operand_stage_pkg::*;
#(
    parameter bit FWD_ALU = 1'b1
) (
    input  logic [REG_W-1:0] r,
    input  logic [XLEN-1:0]  rf_data,
    input  logic             fwd_en,
    input  logic [REG_W-1:0] fwd_rd,
    input  logic [XLEN-1:0]  fwd_data,
    input  logic             wb_en,
    input  logic [REG_W-1:0] wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    output logic [XLEN-1:0]  value
);

    // Pick the youngest producer of r; x0 always reads zero
    always_comb begin
        value = rf_data;
        if (r == '0)
            value = '0;
        else if (FWD_ALU && fwd_en && (fwd_rd == r))
            value = fwd_data;
        else if (wb_en && (wb_rd == r))
            value = wb_data;
    end

endmodule

// File: rtl/alu_operand_stage.sv
// Operand-read stage: resolves bypasses and registers the ALU bundle.
// Shift ops take the amount in sr0 and the shifted value in sr1.
module alu_operand_stage
    import alu_operand_stage_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter bit FWD_ALU = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              stall,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_control,
    input  logic [REG_W-1:0]  in_rd,
    input  logic [REG_W-1:0]  in_rj,
    input  logic [REG_W-1:0]  in_rk,
    input  logic              in_use_imm,
    input  logic [XLEN-1:0]   in_imm,
    output logic [REG_W-1:0]  rf_raddr0,
    output logic [REG_W-1:0]  rf_raddr1,
    input  logic [XLEN-1:0]   rf_rdata0,
    input  logic [XLEN-1:0]   rf_rdata1,
    input  logic              wb_en,
    input  logic [REG_W-1:0]  wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              fwd_en,
    input  logic [REG_W-1:0]  fwd_rd,
    input  logic [XLEN-1:0]   fwd_data,
    output logic              alu_en_in,
    output logic [CTRL_W-1:0] alu_control,
    output logic [REG_W-1:0]  alu_rd_in,
    output logic [XLEN-1:0]   alu_sr0,
    output logic [XLEN-1:0]   alu_sr1,
    output logic [CNT_W-1:0]  issue_cnt
);

    logic [XLEN-1:0]  val_j;
    logic [XLEN-1:0]  val_k;
    logic [XLEN-1:0]  op2;
    alu_in_t          nxt;
    alu_in_t          q;
    logic [CNT_W-1:0] cnt;

    assign rf_raddr0 = in_rj;
    assign rf_raddr1 = in_rk;
    assign in_ready  = ~stall & ~rst;

    alu_bypass_mux #(.FWD_ALU(FWD_ALU)) u_byp_j (
        .r        (in_rj),
        .rf_data  (rf_rdata0),
        .fwd_en   (fwd_en),
        .fwd_rd   (fwd_rd),
        .fwd_data (fwd_data),
        .wb_en    (wb_en),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .value    (val_j)
    );

    alu_bypass_mux #(.FWD_ALU(FWD_ALU)) u_byp_k (
        .r        (in_rk),
        .rf_data  (rf_rdata1),
        .fwd_en   (fwd_en),
        .fwd_rd   (fwd_rd),
        .fwd_data (fwd_data),
        .wb_en    (wb_en),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .value    (val_k)
    );

    assign op2 = in_use_imm ? in_imm : val_k;

    // Build the bundle the ALU consumes, swapping operands for shifts
    always_comb begin
        nxt         = '0;
        nxt.en      = 1'b1;
        nxt.control = in_control;
        nxt.rd      = in_rd;
        if (is_alu_shift(in_control)) begin
            nxt.sr0 = op2;
            nxt.sr1 = val_j;
        end else begin
            nxt.sr0 = val_j;
            nxt.sr1 = op2;
        end
    end

    // Output register: flush bubbles, stall holds, otherwise advance
    always_ff @(posedge clk) begin
        if (rst) begin
            q   <= '0;
            cnt <= '0;
        end else if (flush) begin
            q <= '0;
        end else if (!stall) begin
            if (in_valid) begin
                q   <= nxt;
                cnt <= cnt + CNT_W'(1);
            end else begin
                q <= '0;
            end
        end
    end

    assign alu_en_in   = q.en;
    assign alu_control = q.control;
    assign alu_rd_in   = q.rd;
    assign alu_sr0     = q.sr0;
    assign alu_sr1     = q.sr1;
    assign issue_cnt   = cnt;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage with a small ALU model
// closing the bypass loop.
module tb_alu_operand_stage;
    import alu_operand_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, stall;
    logic        in_valid, in_ready;
    logic [3:0]  in_control;
    logic [4:0]  in_rd, in_rj, in_rk;
    logic        in_use_imm;
    logic [31:0] in_imm;
    logic [4:0]  rf_raddr0, rf_raddr1;
    logic [31:0] rf_rdata0, rf_rdata1;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        fwd_en;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic        alu_en_in;
    logic [3:0]  alu_control;
    logic [4:0]  alu_rd_in;
    logic [31:0] alu_sr0, alu_sr1;
    logic [31:0] issue_cnt;

    logic        ovr;
    logic [4:0]  ovr_rd;
    logic [31:0] ovr_data;

    int errors = 0;
    int checks = 0;
    alu_in_t exp_q[$];

    always #5 clk = ~clk;

    alu_operand_stage #(.CNT_W(32), .FWD_ALU(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_control(in_control), .in_rd(in_rd), .in_rj(in_rj),
        .in_rk(in_rk), .in_use_imm(in_use_imm), .in_imm(in_imm),
        .rf_raddr0(rf_raddr0), .rf_raddr1(rf_raddr1),
        .rf_rdata0(rf_rdata0), .rf_rdata1(rf_rdata1),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .fwd_en(fwd_en), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .alu_en_in(alu_en_in), .alu_control(alu_control),
        .alu_rd_in(alu_rd_in), .alu_sr0(alu_sr0), .alu_sr1(alu_sr1),
        .issue_cnt(issue_cnt)
    );

    function automatic logic [31:0] alu_model(input logic [3:0] c,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        case (c)
            CTRL_ALU_ADD: return a + b;
            CTRL_ALU_SUB: return a - b;
            CTRL_ALU_AND: return a & b;
            CTRL_ALU_OR:  return a | b;
            CTRL_ALU_XOR: return a ^ b;
            CTRL_ALU_SLL: return b << a[4:0];
            CTRL_ALU_SRL: return b >> a[4:0];
            CTRL_ALU_SRA: return $unsigned($signed(b) >>> a[4:0]);
            default:      return 32'h0;
        endcase
    endfunction

    always_comb begin
        fwd_en   = alu_en_in;
        fwd_rd   = alu_rd_in;
        fwd_data = alu_model(alu_control, alu_sr0, alu_sr1);
        if (ovr) begin
            fwd_en   = 1'b1;
            fwd_rd   = ovr_rd;
            fwd_data = ovr_data;
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every edge that advanced with a valid bundle is scored
    always @(posedge clk) begin
        automatic logic adv = !rst && !flush && !stall;
        alu_in_t e;
        #1;
        if (adv && alu_en_in) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected", 32'(alu_rd_in), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("sb_en",   32'(alu_en_in),   32'(e.en));
                check("sb_ctrl", 32'(alu_control), 32'(e.control));
                check("sb_rd",   32'(alu_rd_in),   32'(e.rd));
                check("sb_sr0",  alu_sr0,          e.sr0);
                check("sb_sr1",  alu_sr1,          e.sr1);
            end
        end
    end

    task automatic send(input logic [3:0] c, input logic [4:0] d,
                        input logic [4:0] j, input logic [4:0] k,
                        input logic ui, input logic [31:0] im,
                        input logic [31:0] r0, input logic [31:0] r1,
                        input logic [31:0] e0, input logic [31:0] e1);
        in_valid   = 1'b1;
        in_control = c;
        in_rd      = d;
        in_rj      = j;
        in_rk      = k;
        in_use_imm = ui;
        in_imm     = im;
        rf_rdata0  = r0;
        rf_rdata1  = r1;
        if (!stall && !flush)
            exp_q.push_back(alu_in_t'{1'b1, c, d, e0, e1});
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
        in_control = '0; in_rd = '0; in_rj = '0; in_rk = '0;
        in_use_imm = 1'b0; in_imm = '0; rf_rdata0 = '0; rf_rdata1 = '0;
        wb_en = 1'b0; wb_rd = '0; wb_data = '0;
        ovr = 1'b0; ovr_rd = '0; ovr_data = '0;

        repeat (2) @(negedge clk);
        check("rst_en",    32'(alu_en_in),   32'h0);
        check("rst_ctrl",  32'(alu_control), 32'h0);
        check("rst_rd",    32'(alu_rd_in),   32'h0);
        check("rst_sr0",   alu_sr0,          32'h0);
        check("rst_sr1",   alu_sr1,          32'h0);
        check("rst_cnt",   issue_cnt,        32'h0);
        check("rst_ready", 32'(in_ready),    32'h0);
        rst = 1'b0;
        #1;
        check("rel_ready", 32'(in_ready), 32'h1);
        @(negedge clk);

        send(CTRL_ALU_ADD, 5'd10, 5'd1, 5'd2, 1'b0, 32'h0,
             32'd5, 32'd7, 32'd5, 32'd7);
        send(CTRL_ALU_SLL, 5'd11, 5'd3, 5'd0, 1'b1, 32'd4,
             32'h1, 32'h0, 32'd4, 32'h1);
        check("sll_result",
              alu_model(alu_control, alu_sr0, alu_sr1), 32'h10);

        send(CTRL_ALU_ADD, 5'd4, 5'd1, 5'd2, 1'b0, 32'h0,
             32'd5, 32'd7, 32'd5, 32'd7);
        wb_en = 1'b1; wb_rd = 5'd4; wb_data = 32'hDEAD;
        send(CTRL_ALU_SUB, 5'd5, 5'd4, 5'd1, 1'b0, 32'h0,
             32'h99, 32'd5, 32'd12, 32'd5);
        wb_en = 1'b0;

        ovr = 1'b1; ovr_rd = 5'd0; ovr_data = 32'hFFFF;
        send(CTRL_ALU_OR, 5'd7, 5'd0, 5'd0, 1'b1, 32'h55,
             32'h1, 32'h2, 32'h0, 32'h55);
        ovr = 1'b0;

        wb_en = 1'b1; wb_rd = 5'd6; wb_data = 32'h1234;
        send(CTRL_ALU_ADD, 5'd8, 5'd6, 5'd9, 1'b0, 32'h0,
             32'h1, 32'h2, 32'h1234, 32'h2);
        wb_en = 1'b0;

        send(CTRL_ALU_SRA, 5'd12, 5'd13, 5'd14, 1'b0, 32'h0,
             32'h8000_0000, 32'd3, 32'd3, 32'h8000_0000);
        send(4'hF, 5'd1, 5'd1, 5'd2, 1'b0, 32'h0,
             32'd3, 32'd4, 32'd3, 32'd4);
        send(CTRL_ALU_ADD, 5'd15, 5'd20, 5'd21, 1'b0, 32'h0,
             32'h11, 32'h22, 32'h11, 32'h22);

        stall = 1'b1;
        send(CTRL_ALU_SUB, 5'd30, 5'd1, 5'd2, 1'b0, 32'h0,
             32'h5, 32'h6, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            check("stall_ready", 32'(in_ready),  32'h0);
            check("stall_en",    32'(alu_en_in), 32'h1);
            check("stall_rd",    32'(alu_rd_in), 32'd15);
            check("stall_sr0",   alu_sr0,        32'h11);
            check("stall_sr1",   alu_sr1,        32'h22);
            check("stall_cnt",   issue_cnt,      32'd9);
            if (i < 2) @(negedge clk);
        end
        stall = 1'b0;

        send(CTRL_ALU_XOR, 5'd16, 5'd15, 5'd0, 1'b1, 32'hF0,
             32'h77, 32'h0, 32'h33, 32'hF0);

        flush = 1'b1; stall = 1'b1; in_valid = 1'b1;
        #1;
        check("fl_st_ready", 32'(in_ready), 32'h0);
        @(negedge clk);
        check("flush_en",  32'(alu_en_in), 32'h0);
        check("flush_rd",  32'(alu_rd_in), 32'h0);
        check("flush_sr0", alu_sr0,        32'h0);
        check("flush_sr1", alu_sr1,        32'h0);
        check("flush_cnt", issue_cnt,      32'd10);
        stall = 1'b0;
        #1;
        check("flush_ready", 32'(in_ready), 32'h1);
        @(negedge clk);
        check("flush2_en",  32'(alu_en_in), 32'h0);
        check("flush2_cnt", issue_cnt,      32'd10);
        flush = 1'b0; in_valid = 1'b0;

        repeat (3) @(negedge clk);
        check("idle_en",  32'(alu_en_in), 32'h0);
        check("sb_drain", 32'(exp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
